// File: rtl/eci_mob_credit_gate_pkg.sv
// Shared constants and types for the ECI MOB credit gate.
package eci_mob_credit_gate_pkg;

    localparam int NUM_VC       = 13;
    localparam int INIT_CREDITS = 8;
    localparam int MAX_CREDITS  = 15;
    localparam int CREDIT_W     = 4;
    localparam int VC_W         = 4;
    localparam int DATA_W       = 64;
    localparam int HI_WORDS     = 9;

    typedef logic [CREDIT_W-1:0] credit_t;
    typedef logic [VC_W-1:0]     vc_t;

    // VC numbers beyond the implemented range are accepted but dropped.
    function automatic logic vc_is_bad(input vc_t vc);
        return vc >= vc_t'(NUM_VC);
    endfunction

endpackage

// File: rtl/eci_mob_credit_gate_if.sv
// Upstream and link-side handshake bundle. The gate uses the slave view;
// the surrounding environment (upstream source plus link sink) uses master.
interface eci_mob_credit_gate_if;
    import eci_mob_credit_gate_pkg::*;

    logic [DATA_W-1:0] in_lo_data;
    vc_t               in_lo_vc_no;
    logic              in_lo_valid;
    logic              in_lo_ready;

    logic [DATA_W-1:0] in_hi_data [HI_WORDS-1:0];
    vc_t               in_hi_vc_no;
    logic [2:0]        in_hi_size;
    logic              in_hi_valid;
    logic              in_hi_ready;

    logic [DATA_W-1:0] mob_lo_data;
    vc_t               mob_lo_vc_no;
    logic              mob_lo_valid;
    logic              mob_lo_ready;

    logic [DATA_W-1:0] mob_hi_data [HI_WORDS-1:0];
    vc_t               mob_hi_vc_no;
    logic [2:0]        mob_hi_size;
    logic              mob_hi_valid;
    logic              mob_hi_ready;

    modport slave (
        input  in_lo_data, in_lo_vc_no, in_lo_valid,
        output in_lo_ready,
        input  in_hi_data, in_hi_vc_no, in_hi_size, in_hi_valid,
        output in_hi_ready,
        output mob_lo_data, mob_lo_vc_no, mob_lo_valid,
        input  mob_lo_ready,
        output mob_hi_data, mob_hi_vc_no, mob_hi_size, mob_hi_valid,
        input  mob_hi_ready
    );

    modport master (
        output in_lo_data, in_lo_vc_no, in_lo_valid,
        input  in_lo_ready,
        output in_hi_data, in_hi_vc_no, in_hi_size, in_hi_valid,
        input  in_hi_ready,
        input  mob_lo_data, mob_lo_vc_no, mob_lo_valid,
        output mob_lo_ready,
        input  mob_hi_data, mob_hi_vc_no, mob_hi_size, mob_hi_valid,
        output mob_hi_ready
    );

endinterface

// File: rtl/eci_mob_credit_gate_credit_counter.sv
// One per-VC transmit-credit counter: net up/down update, saturating at the
// ceiling, reloaded to the initial count while init is high.
module eci_credit_counter
    import eci_mob_credit_gate_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    init,
    input  logic    ret,
    input  logic    take_lo,
    input  logic    take_hi,
    output credit_t cnt,
    output logic    nonzero,
    output logic    overflow
);

    localparam int SW = CREDIT_W + 1;

    credit_t         r_cnt;
    logic [SW-1:0]   w_sum;
    logic            w_sat;

    // Takes never exceed the current count (ready is gated on it), so the
    // net sum cannot go negative; only a lone return at the ceiling overflows.
    always_comb begin
        w_sum = {1'b0, r_cnt} + SW'(ret) - SW'(take_lo) - SW'(take_hi);
        w_sat = ret && !take_lo && !take_hi && (r_cnt == credit_t'(MAX_CREDITS));
    end

    // Counter register: reload on reset/link down, hold at the ceiling on overflow.
    always_ff @(posedge clk) begin
        if (reset || init)
            r_cnt <= credit_t'(INIT_CREDITS);
        else if (!w_sat)
            r_cnt <= w_sum[CREDIT_W-1:0];
    end

    assign cnt      = r_cnt;
    assign nonzero  = (r_cnt != '0);
    assign overflow = w_sat && !init && !reset;

endmodule

// File: rtl/eci_mob_credit_gate.sv
// Credit gate in front of the ECI link MOB inputs: per-VC credit tracking,
// per-channel one-entry output registers, bad-VC drop and sticky errors.
module eci_mob_credit_gate
    import eci_mob_credit_gate_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              link_up,
    input  logic [NUM_VC-1:0] mob_credit_return,
    eci_mob_credit_gate_if.slave bus,
    output logic [NUM_VC-1:0] credit_avail,
    output logic              err_overflow,
    output logic              err_bad_vc
);

    localparam int VC_SPACE = 2 ** VC_W;

    logic                w_init;
    credit_t             w_cnt [NUM_VC];
    logic [NUM_VC-1:0]   w_nonzero, w_last, w_ovf, w_take_lo, w_take_hi;
    logic [VC_SPACE-1:0] w_nz_pad, w_last_pad;
    logic                w_lo_free, w_hi_free, w_lo_bad, w_hi_bad;
    logic                w_lo_ready, w_hi_ready, w_lo_acc, w_hi_acc;
    logic                w_lo_take, w_hi_take;

    logic                r_lo_valid;
    logic [DATA_W-1:0]   r_lo_data;
    vc_t                 r_lo_vc;
    logic                r_hi_valid;
    logic [DATA_W-1:0]   r_hi_data [HI_WORDS-1:0];
    vc_t                 r_hi_vc;
    logic [2:0]          r_hi_size;
    logic                r_err_ovf, r_err_bad;

    assign w_init = reset || !link_up;

    // Padded to the full VC number space so out-of-range VCs index zeros.
    assign w_nz_pad   = VC_SPACE'(w_nonzero);
    assign w_last_pad = VC_SPACE'(w_last);

    // Ready/accept: hi wins the last credit of a VC; lo is masked in that case.
    always_comb begin
        w_lo_free  = !r_lo_valid || bus.mob_lo_ready;
        w_hi_free  = !r_hi_valid || bus.mob_hi_ready;
        w_lo_bad   = vc_is_bad(bus.in_lo_vc_no);
        w_hi_bad   = vc_is_bad(bus.in_hi_vc_no);
        w_hi_ready = link_up && w_hi_free && (w_hi_bad || w_nz_pad[bus.in_hi_vc_no]);
        w_hi_acc   = bus.in_hi_valid && w_hi_ready;
        w_hi_take  = w_hi_acc && !w_hi_bad;
        w_lo_ready = link_up && w_lo_free &&
                     (w_lo_bad || (w_nz_pad[bus.in_lo_vc_no] &&
                      !(w_hi_take && (bus.in_hi_vc_no == bus.in_lo_vc_no) &&
                        w_last_pad[bus.in_lo_vc_no])));
        w_lo_acc   = bus.in_lo_valid && w_lo_ready;
        w_lo_take  = w_lo_acc && !w_lo_bad;
    end

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        assign w_take_lo[i] = w_lo_take && (bus.in_lo_vc_no == vc_t'(i));
        assign w_take_hi[i] = w_hi_take && (bus.in_hi_vc_no == vc_t'(i));
        assign w_last[i]    = (w_cnt[i] == credit_t'(1));

        eci_credit_counter u_cnt (
            .clk      (clk),
            .reset    (reset),
            .init     (w_init),
            .ret      (mob_credit_return[i]),
            .take_lo  (w_take_lo[i]),
            .take_hi  (w_take_hi[i]),
            .cnt      (w_cnt[i]),
            .nonzero  (w_nonzero[i]),
            .overflow (w_ovf[i])
        );
    end

    // Lo output stage: load on accept, drain when the link takes it.
    always_ff @(posedge clk) begin
        if (w_init) begin
            r_lo_valid <= 1'b0;
            r_lo_data  <= '0;
            r_lo_vc    <= '0;
        end else if (w_lo_free) begin
            r_lo_valid <= w_lo_take;
            if (w_lo_take) begin
                r_lo_data <= bus.in_lo_data;
                r_lo_vc   <= bus.in_lo_vc_no;
            end
        end
    end

    // Hi output stage: same as lo, with the multi-word payload and size code.
    always_ff @(posedge clk) begin
        if (w_init) begin
            r_hi_valid <= 1'b0;
            r_hi_data  <= '{default: '0};
            r_hi_vc    <= '0;
            r_hi_size  <= '0;
        end else if (w_hi_free) begin
            r_hi_valid <= w_hi_take;
            if (w_hi_take) begin
                r_hi_data <= bus.in_hi_data;
                r_hi_vc   <= bus.in_hi_vc_no;
                r_hi_size <= bus.in_hi_size;
            end
        end
    end

    // Sticky error flags; only reset clears them, link_up does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_ovf <= 1'b0;
            r_err_bad <= 1'b0;
        end else begin
            if (|w_ovf)
                r_err_ovf <= 1'b1;
            if ((w_lo_acc && w_lo_bad) || (w_hi_acc && w_hi_bad))
                r_err_bad <= 1'b1;
        end
    end

    assign bus.in_lo_ready  = w_lo_ready;
    assign bus.in_hi_ready  = w_hi_ready;
    assign bus.mob_lo_valid = r_lo_valid;
    assign bus.mob_lo_data  = r_lo_data;
    assign bus.mob_lo_vc_no = r_lo_vc;
    assign bus.mob_hi_valid = r_hi_valid;
    assign bus.mob_hi_data  = r_hi_data;
    assign bus.mob_hi_vc_no = r_hi_vc;
    assign bus.mob_hi_size  = r_hi_size;
    assign credit_avail     = w_nonzero;
    assign err_overflow     = r_err_ovf;
    assign err_bad_vc       = r_err_bad;

endmodule

// File: tb/tb_eci_mob_credit_gate.sv
// Directed bench for the ECI MOB credit gate.
module tb_eci_mob_credit_gate;
    import eci_mob_credit_gate_pkg::*;

    logic              clk;
    logic              reset;
    logic              link_up;
    logic [NUM_VC-1:0] mob_credit_return;
    logic [NUM_VC-1:0] credit_avail;
    logic              err_overflow;
    logic              err_bad_vc;

    int n_cmp = 0;
    int n_bad = 0;

    eci_mob_credit_gate_if bus ();

    eci_mob_credit_gate dut (
        .clk               (clk),
        .reset             (reset),
        .link_up           (link_up),
        .mob_credit_return (mob_credit_return),
        .bus               (bus),
        .credit_avail      (credit_avail),
        .err_overflow      (err_overflow),
        .err_bad_vc        (err_bad_vc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reinit();
        bus.in_lo_valid = 1'b0;
        bus.in_hi_valid = 1'b0;
        link_up = 1'b0;
        cyc();
        link_up = 1'b1;
    endtask

    // Streams lo messages on one VC until ready drops; returns how many went.
    task automatic drain_lo(input logic [3:0] vc, output int n);
        n = 0;
        bus.in_lo_vc_no  = vc;
        bus.in_lo_valid  = 1'b1;
        bus.mob_lo_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!bus.in_lo_ready) break;
            n++;
            cyc();
        end
        bus.in_lo_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        link_up = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        #1;
        n_cmp++; if (credit_avail !== 13'h1FFF) begin n_bad++; $display("FAIL reset_avail: got %h expected 1fff", credit_avail); end
        n_cmp++; if (bus.mob_lo_valid !== 1'b0 || bus.mob_hi_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got lo=%b hi=%b expected 0", bus.mob_lo_valid, bus.mob_hi_valid); end
        n_cmp++; if (err_overflow !== 1'b0 || err_bad_vc !== 1'b0) begin n_bad++; $display("FAIL reset_err: got ovf=%b bad=%b expected 0", err_overflow, err_bad_vc); end
        n_cmp++; if (bus.in_lo_ready !== 1'b1 || bus.in_hi_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got lo=%b hi=%b expected 1", bus.in_lo_ready, bus.in_hi_ready); end
        cyc();
    endtask

    task automatic test_lo_exhaust();
        reinit();
        bus.mob_lo_ready = 1'b1;
        bus.in_lo_vc_no  = 4'd6;
        bus.in_lo_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_lo_data = 64'h600 + 64'(i);
            #1;
            n_cmp++; if (bus.in_lo_ready !== 1'b1) begin n_bad++; $display("FAIL exh_ready%0d: got %b expected 1", i, bus.in_lo_ready); end
            cyc();
            n_cmp++; if (bus.mob_lo_valid !== 1'b1 || bus.mob_lo_data !== 64'h600 + 64'(i) || bus.mob_lo_vc_no !== 4'd6) begin n_bad++; $display("FAIL exh_out%0d: got v=%b d=%h vc=%0d expected v=1 d=%h vc=6", i, bus.mob_lo_valid, bus.mob_lo_data, bus.mob_lo_vc_no, 64'h600 + 64'(i)); end
        end
        bus.in_lo_data = 64'h608;
        #1;
        n_cmp++; if (bus.in_lo_ready !== 1'b0) begin n_bad++; $display("FAIL exh_9th_stall: got %b expected 0", bus.in_lo_ready); end
        n_cmp++; if (credit_avail[6] !== 1'b0) begin n_bad++; $display("FAIL exh_avail0: got %b expected 0", credit_avail[6]); end
        mob_credit_return = 13'h1 << 6;
        cyc();
        mob_credit_return = '0;
        #1;
        n_cmp++; if (bus.in_lo_ready !== 1'b1 || credit_avail[6] !== 1'b1) begin n_bad++; $display("FAIL exh_ret: got ready=%b avail=%b expected 1/1", bus.in_lo_ready, credit_avail[6]); end
        cyc();
        bus.in_lo_valid = 1'b0;
        n_cmp++; if (bus.mob_lo_valid !== 1'b1 || bus.mob_lo_data !== 64'h608 || credit_avail[6] !== 1'b0) begin n_bad++; $display("FAIL exh_9th_out: got v=%b d=%h avail=%b expected 1/608/0", bus.mob_lo_valid, bus.mob_lo_data, credit_avail[6]); end
        cyc();
    endtask

    task automatic test_same_vc();
        int n;
        reinit();
        bus.mob_lo_ready = 1'b1;
        bus.mob_hi_ready = 1'b1;
        bus.in_lo_vc_no  = 4'd3;
        bus.in_lo_valid  = 1'b1;
        repeat (7) cyc();
        bus.in_hi_vc_no = 4'd3;
        bus.in_hi_size  = 3'd1;
        bus.in_hi_valid = 1'b1;
        #1;
        n_cmp++; if (bus.in_hi_ready !== 1'b1 || bus.in_lo_ready !== 1'b0) begin n_bad++; $display("FAIL last_credit_prio: got hi=%b lo=%b expected hi=1 lo=0", bus.in_hi_ready, bus.in_lo_ready); end
        cyc();
        bus.in_hi_valid = 1'b0;
        bus.in_lo_valid = 1'b0;
        n_cmp++; if (bus.mob_hi_valid !== 1'b1 || bus.mob_lo_valid !== 1'b0 || credit_avail[3] !== 1'b0) begin n_bad++; $display("FAIL last_credit_out: got hv=%b lv=%b avail=%b expected 1/0/0", bus.mob_hi_valid, bus.mob_lo_valid, credit_avail[3]); end
        // With plenty of credits both channels may take the same VC at once.
        reinit();
        bus.in_hi_valid = 1'b1;
        bus.in_lo_valid = 1'b1;
        #1;
        n_cmp++; if (bus.in_hi_ready !== 1'b1 || bus.in_lo_ready !== 1'b1) begin n_bad++; $display("FAIL dual_take: got hi=%b lo=%b expected 1/1", bus.in_hi_ready, bus.in_lo_ready); end
        cyc();
        bus.in_hi_valid = 1'b0;
        bus.in_lo_valid = 1'b0;
        n_cmp++; if (bus.mob_hi_valid !== 1'b1 || bus.mob_lo_valid !== 1'b1) begin n_bad++; $display("FAIL dual_out: got hv=%b lv=%b expected 1/1", bus.mob_hi_valid, bus.mob_lo_valid); end
        drain_lo(4'd3, n);
        n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL dual_left: got %0d credits expected 6", n); end
    endtask

    task automatic test_hi_backpressure();
        int n;
        reinit();
        bus.mob_hi_ready = 1'b0;
        bus.in_hi_vc_no  = 4'd1;
        bus.in_hi_size   = 3'd5;
        for (int k = 0; k < HI_WORDS; k++) bus.in_hi_data[k] = 64'hA0 + 64'(k);
        bus.in_hi_valid = 1'b1;
        #1;
        n_cmp++; if (bus.in_hi_ready !== 1'b1) begin n_bad++; $display("FAIL bp_first: got %b expected 1", bus.in_hi_ready); end
        cyc();
        for (int k = 0; k < HI_WORDS; k++) bus.in_hi_data[k] = 64'hB0 + 64'(k);
        bus.in_hi_size = 3'd2;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (bus.in_hi_ready !== 1'b0 || bus.mob_hi_valid !== 1'b1 || bus.mob_hi_data[0] !== 64'hA0 || bus.mob_hi_data[8] !== 64'hA8 || bus.mob_hi_size !== 3'd5 || bus.mob_hi_vc_no !== 4'd1) begin
                n_bad++; $display("FAIL bp_hold%0d: got rdy=%b v=%b d0=%h d8=%h sz=%0d vc=%0d expected 0/1/a0/a8/5/1", c, bus.in_hi_ready, bus.mob_hi_valid, bus.mob_hi_data[0], bus.mob_hi_data[8], bus.mob_hi_size, bus.mob_hi_vc_no);
            end
            cyc();
        end
        bus.mob_hi_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_hi_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b expected 1", bus.in_hi_ready); end
        cyc();
        bus.in_hi_valid = 1'b0;
        n_cmp++; if (bus.mob_hi_data[0] !== 64'hB0 || bus.mob_hi_size !== 3'd2) begin n_bad++; $display("FAIL bp_second: got d0=%h sz=%0d expected b0/2", bus.mob_hi_data[0], bus.mob_hi_size); end
        drain_lo(4'd1, n);
        n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL bp_credits: got %0d expected 6", n); end
    endtask

    task automatic test_overflow();
        int n;
        reinit();
        mob_credit_return = 13'h1 << 10;
        repeat (7) cyc();
        #1;
        n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b expected 0", err_overflow); end
        cyc();
        mob_credit_return = '0;
        n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b expected 1", err_overflow); end
        drain_lo(4'd10, n);
        n_cmp++; if (n !== 15) begin n_bad++; $display("FAIL ovf_sat: got %0d credits expected 15", n); end
        reinit();
        cyc();
        n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b expected 1", err_overflow); end
    endtask

    task automatic test_link_drop();
        int n;
        reinit();
        bus.mob_lo_ready = 1'b1;
        bus.in_lo_vc_no  = 4'd2;
        bus.in_lo_data   = 64'h2222;
        bus.in_lo_valid  = 1'b1;
        repeat (5) cyc();
        link_up = 1'b0;
        mob_credit_return = 13'h1 << 2;
        #1;
        n_cmp++; if (bus.in_lo_ready !== 1'b0 || bus.mob_lo_valid !== 1'b1) begin n_bad++; $display("FAIL drop_now: got rdy=%b v=%b expected 0/1", bus.in_lo_ready, bus.mob_lo_valid); end
        cyc();
        bus.in_lo_valid = 1'b0;
        mob_credit_return = '0;
        n_cmp++; if (bus.mob_lo_valid !== 1'b0 || bus.mob_lo_data !== 64'h0) begin n_bad++; $display("FAIL drop_discard: got v=%b d=%h expected 0/0", bus.mob_lo_valid, bus.mob_lo_data); end
        link_up = 1'b1;
        drain_lo(4'd2, n);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL drop_reinit: got %0d credits expected 8", n); end
    endtask

    task automatic test_bad_vc();
        reinit();
        bus.mob_lo_ready = 1'b1;
        bus.in_lo_vc_no  = 4'd14;
        bus.in_lo_data   = 64'hDEAD;
        bus.in_lo_valid  = 1'b1;
        #1;
        n_cmp++; if (bus.in_lo_ready !== 1'b1 || err_bad_vc !== 1'b0) begin n_bad++; $display("FAIL badvc_ready: got rdy=%b err=%b expected 1/0", bus.in_lo_ready, err_bad_vc); end
        cyc();
        bus.in_lo_valid = 1'b0;
        n_cmp++; if (bus.mob_lo_valid !== 1'b0 || err_bad_vc !== 1'b1 || credit_avail !== 13'h1FFF) begin n_bad++; $display("FAIL badvc_drop: got v=%b err=%b avail=%h expected 0/1/1fff", bus.mob_lo_valid, err_bad_vc, credit_avail); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_cmp++; if (err_bad_vc !== 1'b0 || err_overflow !== 1'b0) begin n_bad++; $display("FAIL err_clear: got bad=%b ovf=%b expected 0/0", err_bad_vc, err_overflow); end
    endtask

    initial begin
        reset = 1'b1;
        link_up = 1'b0;
        mob_credit_return = '0;
        bus.in_lo_data   = '0;
        bus.in_lo_vc_no  = '0;
        bus.in_lo_valid  = 1'b0;
        for (int k = 0; k < HI_WORDS; k++) bus.in_hi_data[k] = '0;
        bus.in_hi_vc_no  = '0;
        bus.in_hi_size   = '0;
        bus.in_hi_valid  = 1'b0;
        bus.mob_lo_ready = 1'b1;
        bus.mob_hi_ready = 1'b1;

        test_reset();
        test_lo_exhaust();
        test_same_vc();
        test_hi_backpressure();
        test_overflow();
        test_link_drop();
        test_bad_vc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
